// File: rtl/param_rr_stream_mux.sv
// N-channel, WIDTH-bit stream multiplexer with a one-entry output register.
// A channel is picked either by the sel input (mode=0) or by round-robin
// arbitration starting after the last granted channel (mode=1). The output
// register refills in the same cycle it drains, so full throughput is kept
// while out_ready stays high. out_data/out_chan come only from flops.
module param_rr_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Occupancy of the output register; FULL is exactly out_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   chan_q, chan_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic               load_en;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;
  logic [SEL_W-1:0]   cand;
  logic               take;

  // The register can accept a beat when empty or when it drains this cycle.
  assign load_en = (state_q == EMPTY) || out_ready;
  assign take    = load_en && grant_vld;

  // Pick at most one requesting channel: fixed by sel, or the first valid
  // channel scanning upward (with wrap) from the one after the last grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (mode == 1'b0) begin
      if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = SEL_W'((int'(last_q) + k) % CHANNELS);
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // One-hot accept for the granted channel; held low while in reset.
  always_comb begin
    in_ready = '0;
    if (reset_n && take) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next occupancy state and next contents of the output register.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    case (state_q)
      EMPTY: begin
        if (take) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = take ? FULL : EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (take) begin
      data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      chan_d = grant_idx;
      last_d = grant_idx;
    end
  end

  // State and output register; reset discards any held beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= SEL_W'(CHANNELS - 1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_param_rr_stream_mux.sv
// Self-checking bench for param_rr_stream_mux (4 channels x 8 bits):
// a directed vector table, reset and round-robin sequences, then random
// traffic compared against a behavioural model plus a beat scoreboard.
module tb_param_rr_stream_mux;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [CH-1:0] valid;
    logic          rdy;
    logic [CH-1:0] exp_ready;
    logic          exp_valid;
    logic [SW-1:0] exp_chan;
    logic [W-1:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] chan;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];

  param_rr_stream_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic md, input logic [SW-1:0] s, input logic [CH-1:0] v,
                              input logic r, input logic [CH-1:0] er, input logic ev,
                              input logic [SW-1:0] ec, input logic [W-1:0] ed);
    vec_t t;
    t.mode = md; t.sel = s; t.valid = v; t.rdy = r;
    t.exp_ready = er; t.exp_valid = ev; t.exp_chan = ec; t.exp_data = ed;
    return t;
  endfunction

  // Reference arbitration: fixed select, or the requester at the smallest
  // cyclic distance after the last granted channel.
  function automatic int model_grant(input logic md, input logic [SW-1:0] s,
                                     input logic [CH-1:0] v, input int last);
    int best;
    int bestd;
    int d;
    if (!md) begin
      if (int'(s) < CH && v[s]) return int'(s);
      return -1;
    end
    best  = -1;
    bestd = CH;
    for (int i = 0; i < CH; i++) begin
      if (v[i]) begin
        d = (i - last - 1 + 2 * CH) % CH;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [W-1:0] ch_data(input logic [CH*W-1:0] d, input int g);
    return d[g*W +: W];
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Fixed channel data for the directed part: ch0..ch3.
    logic [CH*W-1:0] fixed_data;
    logic [SW-1:0]   rr_exp [6];
    logic [CH-1:0]   oh;
    logic            m_valid;
    logic [W-1:0]    m_data;
    logic [SW-1:0]   m_chan;
    int              m_last;
    int              g;
    logic            load;
    beat_t           b;

    fixed_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_data    = fixed_data;

    // ---------------- reset state ----------------
    mode     = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_chan", 32'(out_chan), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;

    // ---------------- directed table ----------------
    //        mode sel valid    rdy  exp_ready exp_v chan data
    tbl.push_back(mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5));
    tbl.push_back(mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
    tbl.push_back(mk(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44));
    tbl.push_back(mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00));
    tbl.push_back(mk(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));
    tbl.push_back(mk(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));

    for (int i = 0; i < tbl.size(); i++) begin
      mode      = tbl[i].mode;
      sel       = tbl[i].sel;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d out_chan", i), 32'(out_chan), 32'(tbl[i].exp_chan));
        check($sformatf("tbl%0d out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      end
    end

    // ---------------- async reset while FULL ----------------
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #2;
    check("pre-reset full", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset out_data", 32'(out_data), 32'd0);
    check("midreset out_chan", 32'(out_chan), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;

    // ---------------- round-robin sequence after reset ----------------
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      #1;
      oh = '0;
      oh[rr_exp[i]] = 1'b1;
      check($sformatf("rr%0d in_ready", i), 32'(in_ready), 32'(oh));
      @(posedge clk);
      #1;
      check($sformatf("rr%0d out_chan", i), 32'(out_chan), 32'(rr_exp[i]));
      check($sformatf("rr%0d out_data", i), 32'(out_data), 32'(ch_data(fixed_data, int'(rr_exp[i]))));
    end

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_last  = CH - 1;
    sb.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, CH - 1));
      in_valid  = ($urandom_range(0, 3) == 0) ? CH'(1 << $urandom_range(0, CH - 1))
                                              : CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = CH*W'($urandom);
      #1;
      load = !m_valid || out_ready;
      g    = load ? model_grant(mode, sel, in_valid, m_last) : -1;
      oh   = '0;
      if (g >= 0) oh[g] = 1'b1;
      check("rand in_ready", 32'(in_ready), 32'(oh));
      // Beat leaving the output this edge must be the oldest one accepted.
      if (m_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb underflow", 32'd1, 32'd0);
        end else begin
          b = sb.pop_front();
          check("sb data", 32'(out_data), 32'(b.data));
          check("sb chan", 32'(out_chan), 32'(b.chan));
        end
      end
      if (load) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_data  = ch_data(in_data, g);
          m_chan  = SW'(g);
          m_last  = g;
          b.data  = m_data;
          b.chan  = m_chan;
          sb.push_back(b);
        end else begin
          m_valid = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      check("rand out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("rand out_data", 32'(out_data), 32'(m_data));
        check("rand out_chan", 32'(out_chan), 32'(m_chan));
      end
    end
    check("sb depth", 32'(sb.size()), 32'(m_valid));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
